board_generator: RTL
====================

Name: board_generator

Overview:
- Upstream stage of the Buscaminas game core.
- On a start request it clears an 8x8 board and places a programmable number of mines at pseudo-random cells, never on a designated safe cell.
- It then computes each cell's 8-neighbour mine count.
- The game core latches the finished board when done pulses.

Parameters:
- LFSR_SEED, 8'h01: reset/initial value of the placement LFSR. Must be non-zero.
- MAX_BOMBS, 63: upper clamp on the requested mine count. Must be ≤ 63 so at least one safe cell exists.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  synchronous, active-low reset; sampled on the rising edge of clk.
- start  input  1  generation request; level-sampled in IDLE only.
- bombs  input  8  requested mine count; effective count P = min(bombs, MAX_BOMBS).
- safe_row  input  3  row of the cell that must not be mined.
- safe_col  input  3  column of the cell that must not be mined.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse; the board is complete.
- board_out  output  8 x [0:7][0:7]  cell array. Each cell is encoded as:
  - bit4 = mine;
  - bits3:0 = neighbour mine count (0-8);
  - bits7:5 = 0 (reserved for downstream hidden/flag state).

Behaviour:
- Reset (rst=0 at a rising edge), from any state including mid-generation:
  - state=IDLE, busy=0, done=0;
  - every board_out cell = 8'h00;
  - LFSR = LFSR_SEED;
  - mine counter = 0.
- LFSR:
  - 8-bit Galois, feedback mask 8'hB8 (x^8+x^6+x^5+x^4+1), period 255.
  - Advances every clock out of reset, regardless of state.
  - Candidate cell index = lfsr[5:0]; row = index[5:3], col = index[2:0].
- FSM: IDLE -> CLEAR -> PLACE -> COUNT -> DONE -> IDLE. Edge numbering: the edge that samples start=1 in IDLE is edge 0.
  - IDLE: start=1 -> CLEAR. The effective count P, safe_row and safe_col are latched at this edge; later changes to these inputs are ignored until the next start.
  - CLEAR (edge 1): all cells <= 8'h00, remaining <= P. If P=0 -> COUNT, else -> PLACE.
  - PLACE: one candidate per cycle.
    - Accept the candidate if its cell has bit4=0 and it is not the safe cell: set bit4, decrement remaining.
    - Otherwise no change.
    - Exit to COUNT on the edge where remaining reaches 0.
    - Every index appears within any 255 consecutive LFSR states, so PLACE lasts at most 255 cycles.
  - COUNT: 64 cycles, cells in row-major order 0..63, one per cycle.
    - Write bits3:0 = number of in-bounds neighbours (max 8) with bit4=1.
    - Edge and corner cells count only existing neighbours; there is no wrap-around.
    - Mine cells also receive their count.
    - bit4 is unchanged in this state.
  - DONE: exactly one cycle, done=1, then -> IDLE.
- Latency: with PLACE lasting K cycles (K=0 when P=0), COUNT occupies edges 2+K..65+K and done is high in the cycle after edge 65+K.
- board_out is stable whenever busy=0. Downstream must not sample it while busy=1.
- start is ignored while busy=1.
  - start held high continuously restarts generation the cycle after DONE: IDLE is visited for one cycle, then edge 0 again.
- Identical reset-to-start timing with identical inputs produces an identical board (deterministic).

Test Plan:
1. Reset; bombs=0, safe=(0,0); pulse start:
   - busy rises after edge 0;
   - done is high exactly one cycle, after edge 65;
   - all 64 cells = 8'h00.
2. bombs=63, safe=(3,4):
   - done within 65+255 cycles of start;
   - cell(3,4) = 8'h08;
   - all other cells have bit4=1;
   - cell(0,0) = 8'h13, cell(7,7) = 8'h13, cell(0,3) = 8'h15.
3. bombs=200, safe=(3,4): result identical to scenario 2 (clamp to 63).
4. bombs=10, safe=(5,2):
   - exactly 10 cells have bit4=1, and (5,2) is not one of them;
   - every bits3:0 value matches a reference-model neighbour count;
   - bits7:5 = 0 everywhere;
   - repeating from reset with the same timing gives a bit-identical board.
5. Start a bombs=20 run; drive rst=0 for one edge during PLACE:
   - next cycle busy=0, done=0, all cells 8'h00, no done pulse is ever emitted for the aborted run;
   - a fresh start completes normally.
6. Pulse start again at edges 3 and 40 of a running generation:
   - both pulses are ignored;
   - a single done pulse is produced;
   - changing bombs/safe_row/safe_col mid-run has no effect on the result.

Source files
------------

// File: rtl/board_generator.sv
// Board generator for the Buscaminas core: clears an 8x8 board, scatters
// mines from an LFSR while avoiding one safe cell, then fills in every
// cell's neighbour mine count before pulsing done for one cycle.
module board_generator #(
  parameter logic [7:0] LFSR_SEED = 8'h01,
  parameter int         MAX_BOMBS = 63
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [7:0]             bombs,
  input  logic [2:0]             safe_row,
  input  logic [2:0]             safe_col,
  output logic                   busy,
  output logic                   done,
  output logic [0:7][0:7][7:0]   board_out
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_PLACE,
    S_COUNT,
    S_DONE
  } state_t;

  state_t      state;
  state_t      next_state;
  logic [7:0]  lfsr;
  logic [5:0]  remaining;
  logic [5:0]  mines_req;
  logic [2:0]  target_row;
  logic [2:0]  target_col;
  logic [5:0]  cell_idx;
  logic [5:0]  clamped;
  logic [5:0]  candidate;
  logic        accept;
  logic [3:0]  neighbours;
  logic [3:0]  nr;
  logic [3:0]  nc;

  assign clamped   = (bombs > 8'(MAX_BOMBS)) ? 6'(MAX_BOMBS) : bombs[5:0];
  assign candidate = lfsr[5:0];
  assign accept    = (state == S_PLACE)
                   && !board_out[candidate[5:3]][candidate[2:0]][4]
                   && (candidate != {target_row, target_col});

  // State register; reset returns to idle from anywhere.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state decode plus the Moore busy/done outputs.
  always_comb begin
    next_state = state;
    busy       = (state != S_IDLE);
    done       = (state == S_DONE);
    unique case (state)
      S_IDLE:  if (start) next_state = S_CLEAR;
      S_CLEAR: next_state = (mines_req == 6'd0) ? S_COUNT : S_PLACE;
      S_PLACE: if (accept && (remaining == 6'd1)) next_state = S_COUNT;
      S_COUNT: if (cell_idx == 6'd63) next_state = S_DONE;
      S_DONE:  next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  // Count mines among the in-bounds neighbours of the cell being scored; an
  // offset row/column of -1 or 8 lands with bit3 set and is skipped.
  always_comb begin
    neighbours = 4'd0;
    nr         = 4'd0;
    nc         = 4'd0;
    for (int dr = 0; dr < 3; dr++) begin
      for (int dc = 0; dc < 3; dc++) begin
        nr = {1'b0, cell_idx[5:3]} + 4'(dr) - 4'd1;
        nc = {1'b0, cell_idx[2:0]} + 4'(dc) - 4'd1;
        if (((dr != 1) || (dc != 1)) && !nr[3] && !nc[3]
            && board_out[nr[2:0]][nc[2:0]][4]) begin
          neighbours = neighbours + 4'd1;
        end
      end
    end
  end

  // Datapath: free-running LFSR, request latching, board clear, mine
  // placement and per-cell neighbour count write-back.
  always_ff @(posedge clk) begin
    if (!rst) begin
      lfsr       <= LFSR_SEED;
      remaining  <= 6'd0;
      mines_req  <= 6'd0;
      target_row <= 3'd0;
      target_col <= 3'd0;
      cell_idx   <= 6'd0;
      board_out  <= '0;
    end else begin
      lfsr <= {1'b0, lfsr[7:1]} ^ (lfsr[0] ? 8'hB8 : 8'h00);
      case (state)
        S_IDLE: begin
          if (start) begin
            mines_req  <= clamped;
            target_row <= safe_row;
            target_col <= safe_col;
          end
        end
        S_CLEAR: begin
          board_out <= '0;
          remaining <= mines_req;
          cell_idx  <= 6'd0;
        end
        S_PLACE: begin
          if (accept) begin
            board_out[candidate[5:3]][candidate[2:0]][4] <= 1'b1;
            remaining <= remaining - 6'd1;
          end
        end
        S_COUNT: begin
          board_out[cell_idx[5:3]][cell_idx[2:0]][3:0] <= neighbours;
          cell_idx <= cell_idx + 6'd1;
        end
        default: ;
      endcase
    end
  end

endmodule
